// File: rtl/bb_mem_ctrl_if.sv
// bb_mem_ctrl_if: req/ack memory bus between the controller and external memory.
interface bb_mem_ctrl_if #(parameter int DATA_WIDTH = 16);
  logic req;
  logic we;
  logic ifetch;
  logic ack;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  modport master(output req, we, ifetch, addr, wdata, input ack, rdata);
  modport slave(input req, we, ifetch, addr, wdata, output ack, rdata);
endinterface

// File: rtl/bb_mem_ctrl.sv
// bb_mem_ctrl: core-to-bus memory controller with posted writes, blocking reads and a watchdog.
module bb_mem_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT = 64,
  parameter int CNT_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            action,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  busy,
  output logic                  err,
  bb_mem_ctrl_if.master         mem
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RD_DONE} state_t;
  localparam logic [1:0] NOP = 2'b00, WRITE = 2'b10, FETCH = 2'b11;
  localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] WD_MAX = '1;
  state_t state, nxt;
  logic [CNT_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] rdata_q, addr_q, wdata_q;
  logic we_q, ifetch_q, waiting, done, abort, accept;
  assign mem.req = waiting;
  assign mem.we = we_q;
  assign mem.ifetch = ifetch_q;
  assign mem.addr = addr_q;
  assign mem.wdata = wdata_q;
  always_comb begin
    waiting = state == RD_WAIT || state == WR_WAIT;
    done = waiting && mem.ack;
    abort = waiting && !mem.ack && wd == WD_LAST;
    accept = state == IDLE && action != NOP;
    nxt = state == IDLE ? (action[0] ? RD_WAIT : action[1] ? WR_WAIT : IDLE)
        : state == RD_WAIT ? (done || abort ? RD_DONE : RD_WAIT)
        : state == WR_WAIT ? (done || abort ? IDLE : WR_WAIT)
        : IDLE;
    // a write is posted, so the core is only stalled by a second request behind it
    busy = !rst && (state == IDLE ? action[0] : state == RD_WAIT ? 1'b1 : state == WR_WAIT ? action != NOP : 1'b0);
    rvalid = state == RD_DONE;
    rdata = rvalid ? rdata_q : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd <= '0;
      rdata_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      ifetch_q <= 1'b0;
      err <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= addr;
        we_q <= action == WRITE;
        ifetch_q <= action == FETCH;
        if (action == WRITE) wdata_q <= wdata;
      end
      wd <= waiting && !mem.ack ? (wd == WD_MAX ? wd : wd + 1'b1) : '0;
      if (state == RD_WAIT && (done || abort)) rdata_q <= done ? mem.rdata : '1;
      if (abort) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bb_mem_ctrl.sv
// tb_bb_mem_ctrl: directed stimulus with a scoreboard monitor for bb_mem_ctrl.
module tb_bb_mem_ctrl;
  typedef struct {
    logic we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic ifetch;
  } bus_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] action = 2'b00;
  logic [15:0] addr = '0, wdata = '0, rdata;
  logic rvalid, busy, err;
  logic ack_r = 1'b0, stray = 1'b0, req_prev = 1'b0;
  logic [15:0] rdata_r = '0, rd_val = '0;
  int ack_dly = 0, wcnt = 0, n_cmp = 0, n_bad = 0, nb;
  bus_t bq[$];
  logic [15:0] rq[$];
  bb_mem_ctrl_if #(.DATA_WIDTH(16)) bus ();
  assign bus.ack = ack_r | stray;
  assign bus.rdata = rdata_r;
  bb_mem_ctrl #(.DATA_WIDTH(16), .TIMEOUT(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .action(action), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .busy(busy), .err(err), .mem(bus.master)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // present a request and hold it while busy; nbusy counts stalled cycles
  task automatic op(input logic [1:0] act, input logic [15:0] a, input logic [15:0] d,
                    input logic [15:0] exp_rd, output int nbusy);
    bus_t t;
    logic b;
    bit ok = 0;
    t.we = act == 2'b10;
    t.addr = a;
    t.wdata = d;
    t.ifetch = act == 2'b11;
    bq.push_back(t);
    if (act[0]) rq.push_back(exp_rd);
    action = act;
    addr = a;
    wdata = d;
    nbusy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      b = busy;
      tick();
      if (!b) begin
        ok = 1;
        break;
      end
      nbusy++;
    end
    if (!ok) chk("op_timeout", 0, 1);
    action = 2'b00;
  endtask
  initial forever begin
    tick();
    ack_r = bus.req && wcnt == ack_dly;
    rdata_r = ack_r ? rd_val : 16'h0;
    wcnt = bus.req ? wcnt + 1 : 0;
  end
  always @(negedge clk) begin
    bus_t t;
    if (!rst) begin
      if (rvalid) begin
        if (rq.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_data", rdata, rq.pop_front());
      end else chk("rdata_idle", rdata, 0);
      if (bus.req && !req_prev) begin
        if (bq.size() == 0) chk("bus_unexpected", 1, 0);
        else begin
          t = bq.pop_front();
          chk("bus_we", bus.we, t.we);
          chk("bus_addr", bus.addr, t.addr);
          chk("bus_ifetch", bus.ifetch, t.ifetch);
          if (t.we) chk("bus_wdata", bus.wdata, t.wdata);
        end
      end
    end
    req_prev <= bus.req;
  end
  initial begin
    #2;
    chk("rst_req", bus.req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    tick();
    rst = 1'b0;
    // reset while a read is outstanding
    ack_dly = 100;
    bq.push_back('{we: 1'b0, addr: 16'h0040, wdata: 16'h0, ifetch: 1'b0});
    action = 2'b01;
    addr = 16'h0040;
    tick();
    chk("mid_req_up", bus.req, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_req", bus.req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_err", err, 0);
    action = 2'b00;
    tick();
    rst = 1'b0;
    ack_dly = 3;
    rd_val = 16'hBEEF;
    op(2'b01, 16'h0010, 16'h0, 16'hBEEF, nb);
    chk("read_busy_cycles", nb, 5);
    chk("read_err", err, 0);
    ack_dly = 2;
    rd_val = 16'h1234;
    op(2'b10, 16'h0020, 16'h1234, 16'h0, nb);
    chk("write_busy", nb, 0);
    op(2'b01, 16'h0020, 16'h0, 16'h1234, nb);
    chk("rd_after_wr_busy", nb, 7);
    ack_dly = 100;
    op(2'b01, 16'h0030, 16'h0, 16'hFFFF, nb);
    chk("timeout_busy", nb, 9);
    chk("timeout_err", err, 1);
    ack_dly = 0;
    rd_val = 16'h7777;
    op(2'b01, 16'h0031, 16'h0, 16'h7777, nb);
    chk("err_sticky_rd", err, 1);
    op(2'b10, 16'h0032, 16'hAAAA, 16'h0, nb);
    tick();
    tick();
    chk("err_sticky_wr", err, 1);
    rst = 1'b1;
    #1;
    chk("err_cleared", err, 0);
    tick();
    rst = 1'b0;
    ack_dly = 7;
    rd_val = 16'h5A5A;
    op(2'b01, 16'h0050, 16'h0, 16'h5A5A, nb);
    chk("edge_ack_busy", nb, 9);
    chk("edge_ack_err", err, 0);
    ack_dly = 1;
    rd_val = 16'hCAFE;
    op(2'b11, 16'h0100, 16'h0, 16'hCAFE, nb);
    chk("fetch_busy", nb, 3);
    stray = 1'b1;
    tick();
    stray = 1'b0;
    chk("stray_req", bus.req, 0);
    chk("stray_busy", busy, 0);
    chk("stray_rvalid", rvalid, 0);
    tick();
    chk("stray_req2", bus.req, 0);
    rd_val = 16'h0F0F;
    op(2'b01, 16'h0200, 16'h0, 16'h0F0F, nb);
    chk("post_stray_busy", nb, 3);
    tick();
    tick();
    chk("rq_left", rq.size(), 0);
    chk("bq_left", bq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
